accum_stim_driver: RTL and testbench

//  Initiator side of the enable/value accumulator interface. Buffers 32-bit increments

---
 rtl/accum_stim_driver_if.sv | 27 ++
 rtl/accum_stim_driver.sv | 102 ++++++++++
 tb/tb_accum_stim_driver.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_stim_driver_if.sv
// Bundle of the upstream increment port, the accumulator request/readback pair and status.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready handshake on the upstream side; the accumulator side has none.
interface accum_stim_driver_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        enable;
    logic [31:0] value;
    logic [7:0]  led_in;
    logic [31:0] expected;
    logic [15:0] sent_count;
    logic        mismatch;
    logic        busy;

    // Driver side: accepts increments, drives the accumulator, reports status.
    modport master (
        input  in_valid, in_data, led_in,
        output in_ready, enable, value, expected, sent_count, mismatch, busy
    );

    // Environment side: supplies increments and the accumulator readback.
    modport slave (
        output in_valid, in_data, led_in,
        input  in_ready, enable, value, expected, sent_count, mismatch, busy
    );
endinterface

// File: rtl/accum_stim_driver.sv
// Buffers upstream increments and issues them one at a time to the enable/value accumulator, checking its readback.
// Latency: a push is issued (enable high) two cycles after acceptance at best; one transaction per HOLD_CYCLES+2 cycles.
// Backpressure: in_ready drops when the DEPTH-entry FIFO is full; no bypass path.
module accum_stim_driver #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic              CLK,
    input  logic              RST,
    accum_stim_driver_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, CHECK} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill;
    logic [HW-1:0] hold_cnt;
    logic          push, pop;
    logic [31:0]   value_q, expected_q;
    logic [15:0]   sent_q;
    logic          mismatch_q;

    // The head entry leaves the FIFO only on the IDLE->ISSUE transition.
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (state == IDLE) && (fill != '0);

    assign bus.in_ready   = (fill != FULL);
    assign bus.enable     = (state == ISSUE);
    assign bus.value      = value_q;
    assign bus.expected   = expected_q;
    assign bus.sent_count = sent_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.busy       = (state != IDLE) || (fill != '0);

    // FIFO storage; stale entries are harmless because reset clears the pointers.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // State register plus the counter that times the HOLD window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    // Next-state: one cycle each in ISSUE and CHECK, HOLD_CYCLES-1 cycles in HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill != '0) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: value loads only on entry to ISSUE; shadow count and readback check.
    always_ff @(posedge CLK) begin
        if (RST) begin
            value_q    <= '0;
            expected_q <= '0;
            sent_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (pop) value_q <= mem[rd_ptr];
            if (state == ISSUE) expected_q <= expected_q + value_q;
            if (state == CHECK) begin
                sent_q <= sent_q + 1'b1;
                if (bus.led_in != expected_q[23:16]) mismatch_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_accum_stim_driver.sv
// Bench for accum_stim_driver with a behavioural accumulator and a queue-based scoreboard.
// Latency: accumulator adds the held value HOLD cycles after it sees enable.
// Backpressure: stimulus waits on in_ready before each push.
module tb_accum_stim_driver;
    localparam int HOLD = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    accum_stim_driver_if bus ();

    accum_stim_driver #(.DEPTH(4), .HOLD_CYCLES(HOLD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Accumulator model: adds value HOLD cycles after the enable pulse.
    logic [31:0] acc;
    int          acc_tmr;
    logic        led_force;
    always @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            acc_tmr <= 0;
        end else if (bus.enable) begin
            acc_tmr <= HOLD - 1;
        end else if (acc_tmr != 0) begin
            acc_tmr <= acc_tmr - 1;
            if (acc_tmr == 1) acc <= acc + bus.value;
        end
    end
    assign bus.led_in = led_force ? 8'hAA : acc[23:16];

    // Scoreboard state
    logic [31:0] sb_q[$];
    logic [31:0] m_exp;
    int          m_cnt;
    logic        m_mm;
    int          cyc = 0;
    int          chk_at = -1;
    int          last_en = -1;
    logic [31:0] held_v;

    // Monitor: checks each issued value against the queue, its hold window, spacing, and the end-of-transaction status.
    always @(negedge CLK) begin
        logic [31:0] exp_v;
        cyc++;
        if (!RST && last_en >= 0 && (cyc == last_en + 1 || cyc == last_en + 2)) begin
            total++;
            if (bus.value !== held_v) begin
                bad++;
                $display("FAIL value_hold cyc=%0d got=%h want=%h", cyc, bus.value, held_v);
            end
        end
        if (!RST && bus.enable) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL enable_unexpected cyc=%0d value=%h want=no enable", cyc, bus.value);
            end else begin
                exp_v = sb_q.pop_front();
                if (bus.value !== exp_v) begin
                    bad++;
                    $display("FAIL issue_order cyc=%0d got=%h want=%h", cyc, bus.value, exp_v);
                end
                m_exp = m_exp + exp_v;
                held_v = exp_v;
            end
            if (last_en >= 0) begin
                total++;
                if (cyc - last_en < HOLD + 2) begin
                    bad++;
                    $display("FAIL enable_spacing got=%0d want>=%0d", cyc - last_en, HOLD + 2);
                end
            end
            last_en = cyc;
            chk_at  = cyc + HOLD + 1;
        end
        if (!RST && cyc == chk_at) begin
            m_cnt++;
            total++;
            if (bus.sent_count !== 16'(m_cnt) || bus.expected !== m_exp || bus.mismatch !== m_mm) begin
                bad++;
                $display("FAIL txn_end sent=%0d/%0d expected=%h/%h mismatch=%b/%b (got/want)",
                         bus.sent_count, m_cnt, bus.expected, m_exp, bus.mismatch, m_mm);
            end
        end
    end

    task automatic clear_model();
        sb_q.delete();
        m_exp   = '0;
        m_cnt   = 0;
        m_mm    = 1'b0;
        chk_at  = -1;
        last_en = -1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.in_valid = 1'b0;
        clear_model();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_word(input logic [31:0] d, output int stalls);
        stalls = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && stalls < 100) begin
            @(negedge CLK);
            stalls++;
        end
        if (stalls >= 100) begin
            total++;
            bad++;
            $display("FAIL push_timeout data=%h in_ready=%b want=1", d, bus.in_ready);
        end else begin
            sb_q.push_back(d);
        end
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.busy && n < budget);
        total++;
        if (bus.busy) begin
            bad++;
            $display("FAIL %s_timeout busy=%b want=0 after %0d cycles", name, bus.busy, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.in_ready !== 1'b1 || bus.enable !== 1'b0 || bus.value !== 32'h0 || bus.expected !== 32'h0 ||
            bus.sent_count !== 16'h0 || bus.mismatch !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_values rdy=%b en=%b val=%h exp=%h sent=%0d mm=%b busy=%b want 1 0 0 0 0 0 0",
                     bus.in_ready, bus.enable, bus.value, bus.expected, bus.sent_count, bus.mismatch, bus.busy);
        end
    endtask

    task automatic test_single();
        int st;
        do_reset();
        push_word(32'h0001_0000, st);
        total++;
        if (bus.enable !== 1'b0) begin
            bad++;
            $display("FAIL single_early_enable got=%b want=0", bus.enable);
        end
        @(negedge CLK);
        total++;
        if (bus.enable !== 1'b1 || bus.value !== 32'h0001_0000) begin
            bad++;
            $display("FAIL single_issue en=%b val=%h want 1 00010000", bus.enable, bus.value);
        end
        repeat (2) begin
            @(negedge CLK);
            total++;
            if (bus.enable !== 1'b0) begin
                bad++;
                $display("FAIL single_enable_width got=%b want=0", bus.enable);
            end
        end
        @(negedge CLK);
        total++;
        if (bus.busy !== 1'b1 || bus.sent_count !== 16'd0) begin
            bad++;
            $display("FAIL single_check_cycle busy=%b sent=%0d want 1 0", bus.busy, bus.sent_count);
        end
        @(negedge CLK);
        total++;
        if (bus.sent_count !== 16'd1 || bus.expected !== 32'h0001_0000 || bus.mismatch !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done sent=%0d exp=%h mm=%b busy=%b want 1 00010000 0 0",
                     bus.sent_count, bus.expected, bus.mismatch, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        int stall_sum = 0;
        logic [31:0] sum = '0;
        logic [31:0] w;
        do_reset();
        // One word drains immediately into ISSUE, four more fill the FIFO, so the sixth
        // waits until the first transaction returns to IDLE and pops: two stalled cycles.
        for (int i = 0; i < 6; i++) begin
            w = 32'h0001_0000 * (i + 1) + 32'(i);
            sum = sum + w;
            push_word(w, st);
            stall_sum += st;
        end
        total++;
        if (stall_sum !== 2) begin
            bad++;
            $display("FAIL b2b_backpressure stalls=%0d want=2", stall_sum);
        end
        wait_idle(300, "b2b");
        total++;
        if (bus.sent_count !== 16'd6 || bus.expected !== sum || sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_totals sent=%0d exp=%h left=%0d want 6 %h 0",
                     bus.sent_count, bus.expected, sb_q.size(), sum);
        end
    endtask

    task automatic test_wrap();
        int st;
        do_reset();
        push_word(32'hFFFF_FFFF, st);
        push_word(32'h0000_0002, st);
        wait_idle(100, "wrap");
        total++;
        if (bus.expected !== 32'h0000_0001 || bus.mismatch !== 1'b0 || bus.sent_count !== 16'd2) begin
            bad++;
            $display("FAIL wrap exp=%h mm=%b sent=%0d want 00000001 0 2", bus.expected, bus.mismatch, bus.sent_count);
        end
    endtask

    task automatic test_fault();
        int st;
        do_reset();
        led_force = 1'b1;
        m_mm = 1'b1;
        push_word(32'h0002_0000, st);
        wait_idle(100, "fault");
        led_force = 1'b0;
        total++;
        if (bus.mismatch !== 1'b1) begin
            bad++;
            $display("FAIL fault_detect mismatch=%b want=1", bus.mismatch);
        end
        push_word(32'h0001_0000, st);
        wait_idle(100, "fault_good");
        total++;
        if (bus.mismatch !== 1'b1 || bus.expected !== 32'h0003_0000) begin
            bad++;
            $display("FAIL fault_sticky mismatch=%b exp=%h want 1 00030000", bus.mismatch, bus.expected);
        end
        do_reset();
        total++;
        if (bus.mismatch !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear mismatch=%b want=0", bus.mismatch);
        end
    endtask

    task automatic test_reset_in_hold();
        int st;
        logic seen_en = 1'b0;
        do_reset();
        push_word(32'h0004_0000, st);
        push_word(32'h0005_0000, st);
        push_word(32'h0006_0000, st);
        // Enable was seen at the negedge before the last push returned; now in HOLD.
        RST = 1'b1;
        clear_model();
        @(negedge CLK);
        total++;
        if (bus.busy !== 1'b0 || bus.value !== 32'h0 || bus.enable !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_reset busy=%b val=%h en=%b rdy=%b want 0 0 0 1",
                     bus.busy, bus.value, bus.enable, bus.in_ready);
        end
        RST = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (bus.enable) seen_en = 1'b1;
        end
        total++;
        if (seen_en !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_reset_quiet enable_seen=%b busy=%b want 0 0", seen_en, bus.busy);
        end
        push_word(32'h0007_0000, st);
        wait_idle(100, "hold_restart");
        total++;
        if (bus.expected !== 32'h0007_0000 || bus.sent_count !== 16'd1 || bus.mismatch !== 1'b0) begin
            bad++;
            $display("FAIL hold_restart exp=%h sent=%0d mm=%b want 00070000 1 0",
                     bus.expected, bus.sent_count, bus.mismatch);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        led_force    = 1'b0;
        clear_model();
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_fault();
        test_reset_in_hold();
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
